// File: rtl/overlapping_pkg.sv
// Shared constants and the elaboration-time KMP transition function for the
// overlapping sequence detector.
package overlapping_pkg;

  localparam int          DEFAULT_SEQ_LEN = 4;
  localparam logic [15:0] DEFAULT_SEQ     = 16'b1011;

  function automatic int state_width(input int len);
    return $clog2(len + 1);
  endfunction

  // State k means k leading bits of seq (MSB first) are matched. Appends bit b
  // and returns the longest suffix of that string which is also a proper
  // prefix of seq (proper only matters for k == len, giving the overlap).
  function automatic int next_state(input int k, input int b,
                                    input logic [15:0] seq, input int len);
    logic [16:0] s;
    logic        ok;
    logic        found;
    int          result;
    s      = '0;
    found  = 1'b0;
    result = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < k) s[i] = seq[len-1-i];
    end
    s[k] = b[0];
    for (int j = 16; j >= 1; j--) begin
      if (!found && j <= k + 1 && j <= len) begin
        ok = 1'b1;
        for (int t = 0; t < 16; t++) begin
          if (t < j && s[k+1-j+t] != seq[len-1-t]) ok = 1'b0;
        end
        if (ok) begin
          found  = 1'b1;
          result = j;
        end
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/overlapping_next_state.sv
// Pure combinational next-state lookup; the table is built at elaboration
// from the KMP transition function so any pattern works.
module overlapping_next_state
  import overlapping_pkg::*;
#(
  parameter int                 SEQ_LEN = DEFAULT_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_LEN'(DEFAULT_SEQ),
  localparam int                W       = state_width(SEQ_LEN)
) (
  input  logic [W-1:0] i_state,
  input  logic         i_bit,
  output logic [W-1:0] o_next
);

  localparam int ENTRIES = 2 * (SEQ_LEN + 1);

  logic [W-1:0] w_table [ENTRIES];
  logic [W:0]   w_index;

  genvar gi, gb;
  generate
    for (gi = 0; gi <= SEQ_LEN; gi++) begin : g_state
      for (gb = 0; gb < 2; gb++) begin : g_bit
        localparam int NXT = next_state(gi, gb, 16'(SEQ), SEQ_LEN);
        assign w_table[2*gi+gb] = W'(NXT);
      end
    end
  endgenerate

  assign w_index = {i_state, i_bit};

  // Unused binary codes above S_SEQ_LEN fall back to S0.
  always_comb begin
    o_next = '0;
    if (i_state <= W'(SEQ_LEN)) o_next = w_table[w_index];
  end

endmodule

// File: rtl/overlapping.sv
// Moore overlapping serial sequence detector. Optional macro DETECT_COUNT_EN
// adds a saturating 16-bit hit counter output det_count.
module overlapping
  import overlapping_pkg::*;
#(
  parameter int                 SEQ_LEN = DEFAULT_SEQ_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ     = SEQ_LEN'(DEFAULT_SEQ)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data,
  output logic        detected
`ifdef DETECT_COUNT_EN
  ,
  output logic [15:0] det_count
`endif
);

  localparam int           W      = state_width(SEQ_LEN);
  localparam logic [W-1:0] S_LAST = W'(SEQ_LEN);

  logic [W-1:0] r_state;
  logic         r_detected;
  logic [W-1:0] w_next;
  logic         w_hit_next;

  overlapping_next_state #(
    .SEQ_LEN (SEQ_LEN),
    .SEQ     (SEQ)
  ) u_next_state (
    .i_state (r_state),
    .i_bit   (data),
    .o_next  (w_next)
  );

  assign w_hit_next = (w_next == S_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= '0;
      r_detected <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_detected <= w_hit_next;
    end
  end

  assign detected = r_detected;

`ifdef DETECT_COUNT_EN
  logic [15:0] r_count;

  // Counts on the entering edge so the count moves together with detected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_hit_next && r_count != 16'hFFFF) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign det_count = r_count;
`endif

endmodule

// File: tb/tb_overlapping.sv
// Self-checking bench: directed test-plan sequences plus random bits, three
// pattern configurations checked against a sliding-window reference model.
module tb_overlapping;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] data = '0;
  logic [2:0] det;
`ifdef DETECT_COUNT_EN
  logic [15:0] cnt [3];
`endif

  always #5 clk = ~clk;

  overlapping #(.SEQ_LEN(4), .SEQ(4'b1011)) dut0 (
    .clk(clk), .rst(rst), .data(data[0]), .detected(det[0])
`ifdef DETECT_COUNT_EN
    , .det_count(cnt[0])
`endif
  );
  overlapping #(.SEQ_LEN(4), .SEQ(4'b1111)) dut1 (
    .clk(clk), .rst(rst), .data(data[1]), .detected(det[1])
`ifdef DETECT_COUNT_EN
    , .det_count(cnt[1])
`endif
  );
  overlapping #(.SEQ_LEN(5), .SEQ(5'b10101)) dut2 (
    .clk(clk), .rst(rst), .data(data[2]), .detected(det[2])
`ifdef DETECT_COUNT_EN
    , .det_count(cnt[2])
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference model: bit history per instance, hit when last LEN bits == SEQ.
  int          m_len [3] = '{4, 4, 5};
  logic [15:0] m_seq [3] = '{16'b1011, 16'b1111, 16'b10101};
  logic [15:0] m_win [3];
  int          m_hlen[3];
  int          m_cnt [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_hit(input int n);
    logic [15:0] mask;
    mask = 16'((32'd1 << m_len[n]) - 1);
    return (m_hlen[n] >= m_len[n]) && ((m_win[n] & mask) == m_seq[n]);
  endfunction

  // One clock edge; updates model and checks all instances after the edge.
  task automatic tick(input logic rst_v, input logic [2:0] d, input string tag);
    rst  = rst_v;
    data = d;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) begin
      if (!rst_v) begin
        m_win[n]  = '0;
        m_hlen[n] = 0;
        m_cnt[n]  = 0;
      end else begin
        m_win[n] = {m_win[n][14:0], d[n]};
        if (m_hlen[n] < 16) m_hlen[n]++;
        if (model_hit(n) && m_cnt[n] < 65535) m_cnt[n]++;
      end
      check($sformatf("%s.det%0d", tag, n), {31'd0, det[n]},
            {31'd0, (rst_v ? model_hit(n) : 1'b0)});
`ifdef DETECT_COUNT_EN
      check($sformatf("%s.cnt%0d", tag, n), {16'd0, cnt[n]}, m_cnt[n]);
`endif
    end
    $display("tick %-10s rst=%0b data=%03b det=%03b", tag, rst_v, d, det);
  endtask

  // Drives the same bit to all instances and checks dut0 against a fixed pulse list.
  task automatic run_dir(input string tag, input logic [15:0] bits,
                         input logic [15:0] exp, input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = bits[n-1-i];
      tick(1'b1, {3{b}}, tag);
      check($sformatf("%s.fix%0d", tag, i), {31'd0, det[0]}, {31'd0, exp[n-1-i]});
    end
  endtask

  task automatic do_reset(input string tag);
    tick(1'b0, 3'b111, tag);
    tick(1'b0, 3'b111, tag);
    check({tag, ".rstdet"}, {29'd0, det}, 32'd0);
  endtask

  initial begin
    for (int n = 0; n < 3; n++) begin
      m_win[n] = '0; m_hlen[n] = 0; m_cnt[n] = 0;
    end

    do_reset("reset");
`ifdef DETECT_COUNT_EN
    check("reset.cnt0", {16'd0, cnt[0]}, 32'd0);
`endif
    run_dir("first", 16'b1011, 16'b0001, 4);

    do_reset("rst_ov");
    run_dir("overlap", 16'b1011011, 16'b0001001, 7);
`ifdef DETECT_COUNT_EN
    check("overlap.count", {16'd0, cnt[0]}, 32'd2);
`endif

    do_reset("rst_b2b");
    run_dir("b2b", 16'b10111011, 16'b00010001, 8);

    do_reset("rst_nm");
    run_dir("nomatch", 16'b11110000, 16'b0, 8);

    do_reset("rst_mid");
    run_dir("mid_a", 16'b101, 16'b000, 3);
    tick(1'b0, 3'b111, "mid_rst");
    check("mid_rst.det0", {31'd0, det[0]}, 32'd0);
    run_dir("mid_b", 16'b1011, 16'b0001, 4);

    // All-ones pattern on dut1 stays high from the 4th one onward.
    do_reset("rst_ones");
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 3'b111, "ones");
      check($sformatf("ones.fix%0d", i), {31'd0, det[1]}, {31'd0, (i >= 3)});
    end

    do_reset("rst_rand");
    for (int i = 0; i < 100; i++) begin
      logic [2:0] r;
      r[0] = 1'($urandom);
      r[1] = ($urandom_range(3, 0) != 0);
      r[2] = 1'($urandom);
      tick(1'b1, r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
